// File: rtl/debug_scan_controller_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | debug_scan_controller_if : byte stream port + debug_module control   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface debug_scan_controller_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] dbg_config_out;
  logic       dbg_en;
  logic [7:0] dbg_data_in;

  modport master (
    output out_data, out_valid, dbg_config_out, dbg_en,
    input  out_ready, dbg_data_in
  );

  modport slave (
    input  out_data, out_valid, dbg_config_out, dbg_en,
    output out_ready, dbg_data_in
  );
endinterface
`default_nettype wire

// File: rtl/debug_scan_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | debug_scan_controller : walks debug select codes, emits framed bytes |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module debug_scan_controller #(
  parameter logic [7:0] HEADER  = 8'hA5,
  parameter int         NUM_POT = 24
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           mode,
  input  logic [7:0]                     single_sel,
  input  logic                           abort,
  debug_scan_controller_if.master        bus,
  output logic                           busy,
  output logic                           done
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR    = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_SEND   = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam logic [4:0] c_NUM_POT  = 5'(NUM_POT);
  localparam logic [4:0] c_LAST_IDX = 5'(NUM_POT + 2);

  state_t     r_state;
  state_t     w_next_state;
  logic [4:0] r_index;
  logic       r_mode;
  logic [7:0] r_single_sel;
  logic [7:0] r_cap;
  logic [7:0] r_cfg;
  logic       w_hs;
  logic       w_last;
  logic [4:0] w_load_idx;

  // Potentials occupy codes 0..NUM_POT-1; the three spike layers sit at 30..32.
  function automatic logic [7:0] sel_code(input logic [4:0] idx, input logic m,
                                          input logic [7:0] s);
    if (m)
      return s;
    else if (idx < c_NUM_POT)
      return {3'b000, idx};
    else
      return 8'd30 + {3'b000, idx - c_NUM_POT};
  endfunction

  assign w_hs       = bus.out_valid && bus.out_ready;
  assign w_last     = r_mode || (r_index == c_LAST_IDX);
  assign w_load_idx = (r_state == ST_HDR) ? r_index : r_index + 5'd1;

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state  = r_state;
    bus.out_valid = 1'b0;
    bus.out_data  = 8'h00;
    bus.dbg_en    = 1'b0;
    done          = 1'b0;
    busy          = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        if (start) w_next_state = ST_HDR;
      end
      ST_HDR: begin
        bus.out_valid = 1'b1;
        bus.out_data  = HEADER;
        if (w_hs) w_next_state = ST_LOAD;
      end
      ST_LOAD: begin
        bus.dbg_en   = 1'b1;
        w_next_state = ST_SETTLE;
      end
      ST_SETTLE: begin
        w_next_state = ST_SEND;
      end
      ST_SEND: begin
        bus.out_valid = 1'b1;
        bus.out_data  = r_cap;
        if (w_hs) w_next_state = w_last ? ST_DONE : ST_LOAD;
      end
      ST_DONE: begin
        done         = !abort;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
    if (abort && (r_state != ST_IDLE))
      w_next_state = ST_IDLE;
  end

  // The config is staged on the edge entering LOAD so debug_module latches it on the LOAD edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_index      <= 5'd0;
      r_mode       <= 1'b0;
      r_single_sel <= 8'h00;
      r_cap        <= 8'h00;
      r_cfg        <= 8'h00;
    end else begin
      if ((r_state == ST_IDLE) && start) begin
        r_mode       <= mode;
        r_single_sel <= single_sel;
        r_index      <= 5'd0;
      end
      if (r_state == ST_SETTLE)
        r_cap <= bus.dbg_data_in;
      if (w_next_state == ST_LOAD) begin
        r_index <= w_load_idx;
        r_cfg   <= sel_code(w_load_idx, r_mode, r_single_sel);
      end
    end
  end

  assign bus.dbg_config_out = r_cfg;

endmodule
`default_nettype wire

// File: tb/tb_debug_scan_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_debug_scan_controller : random-stimulus bench with debug_module   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_debug_scan_controller;
  localparam logic [7:0] HDRB = 8'hA5;
  localparam int         NP   = 24;

  logic       clk = 1'b0;
  logic       rst, start, mode, abort;
  logic [7:0] single_sel;
  logic       busy, done;

  debug_scan_controller_if bus ();

  debug_scan_controller #(.HEADER(HDRB), .NUM_POT(NP)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .single_sel(single_sel),
    .abort(abort), .bus(bus), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // debug_module stand-in: config register written on en, combinational output mux
  logic [7:0] pot [NP];
  logic [7:0] spk [3];
  logic [7:0] dm_cfg;

  function automatic logic [7:0] dm_lookup(input logic [7:0] code);
    if (int'(code) < NP) return pot[code];
    if (code == 8'd30) return spk[0];
    if (code == 8'd31) return spk[1];
    if (code == 8'd32) return spk[2];
    return 8'h00;
  endfunction

  always @(posedge clk) begin
    if (rst) dm_cfg <= 8'h00;
    else if (bus.dbg_en) dm_cfg <= bus.dbg_config_out;
  end
  always_comb bus.dbg_data_in = dm_lookup(dm_cfg);

  // monitor: collects handshaked bytes and dbg_en configs, checks stall stability
  int         cyc = 0;
  int         start_cyc = 0;
  logic [7:0] rx_q [$];
  logic [7:0] cfg_q [$];
  int         done_cnt = 0;
  int         done_cyc = -1;
  int         hs_cnt = 0;
  logic       p_valid = 1'b0, p_ready = 1'b0, p_abort = 1'b0, p_rst = 1'b1;
  logic [7:0] p_data = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid && bus.out_ready) begin
        rx_q.push_back(bus.out_data);
        hs_cnt++;
      end
      if (bus.dbg_en) cfg_q.push_back(bus.dbg_config_out);
      if (done) begin
        done_cnt++;
        done_cyc = cyc - start_cyc;
      end
      if (p_valid && !p_ready && !p_abort && !p_rst) begin
        total++;
        assert (bus.out_valid === 1'b1 && bus.out_data === p_data) else begin
          bad++;
          $error("FAIL stall_hold observed valid=%b data=%h expected valid=1 data=%h",
                 bus.out_valid, bus.out_data, p_data);
        end
      end
    end
    p_valid = bus.out_valid;
    p_ready = bus.out_ready;
    p_abort = abort;
    p_rst   = rst;
    p_data  = bus.out_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model: frame = header, then debug_module output for each code in scan order
  logic [7:0] exp_codes [$];
  logic [7:0] exp_bytes [$];

  task automatic build_exp(input logic m, input logic [7:0] s);
    exp_codes.delete();
    if (m) exp_codes.push_back(s);
    else begin
      for (int k = 0; k < NP; k++) exp_codes.push_back(8'(k));
      exp_codes.push_back(8'd30);
      exp_codes.push_back(8'd31);
      exp_codes.push_back(8'd32);
    end
    exp_bytes.delete();
    exp_bytes.push_back(HDRB);
    foreach (exp_codes[i]) exp_bytes.push_back(dm_lookup(exp_codes[i]));
  endtask

  task automatic cmp_frame(input string tag);
    chk({tag, "_byte_count"}, rx_q.size(), exp_bytes.size());
    for (int i = 0; i < exp_bytes.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i),
          (i < rx_q.size()) ? {24'h0, rx_q[i]} : 32'hDEAD, {24'h0, exp_bytes[i]});
    chk({tag, "_en_count"}, cfg_q.size(), exp_codes.size());
    for (int i = 0; i < exp_codes.size(); i++)
      chk($sformatf("%s_code%0d", tag, i),
          (i < cfg_q.size()) ? {24'h0, cfg_q[i]} : 32'hDEAD, {24'h0, exp_codes[i]});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic m, input logic [7:0] s);
    rx_q.delete();
    cfg_q.delete();
    done_cnt   = 0;
    done_cyc   = -1;
    hs_cnt     = 0;
    start      = 1'b1;
    mode       = m;
    single_sel = s;
    start_cyc  = cyc;
    step();
    start      = 1'b0;
    mode       = 1'b0;
    single_sel = 8'h00;
  endtask

  // restart_at >= 0 pulses a (to be ignored) single-mode start mid-frame
  task automatic wait_done(input int rdy_pct, input int restart_at);
    for (int k = 0; k < 3000; k++) begin
      if (done_cnt > 0) break;
      bus.out_ready = ($urandom_range(99) < rdy_pct);
      start         = (k == restart_at);
      mode          = (k == restart_at);
      single_sel    = 8'd3;
      step();
    end
    start = 1'b0;
    mode  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    chk("done_count", done_cnt, 1);
    chk("idle_after_done", {31'h0, busy}, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0; single_sel = 8'h00;
    bus.out_ready = 1'b1;
    for (int k = 0; k < NP; k++) pot[k] = 8'(k + 1);
    spk[0] = 8'h11; spk[1] = 8'h22; spk[2] = 8'h33;
    repeat (3) step();

    chk("rst_out_valid", {31'h0, bus.out_valid}, 0);
    chk("rst_out_data", {24'h0, bus.out_data}, 0);
    chk("rst_dbg_en", {31'h0, bus.dbg_en}, 0);
    chk("rst_dbg_cfg", {24'h0, bus.dbg_config_out}, 0);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_done", {31'h0, done}, 0);
    rst = 1'b0;
    step();

    // full scan, no backpressure, known channel values
    build_exp(1'b0, 8'h00);
    do_start(1'b0, 8'h00);
    wait_done(100, -1);
    cmp_frame("full");
    chk("full_done_cycle", done_cyc, 83);
    chk("full_cfg_hold", {24'h0, bus.dbg_config_out}, 32);

    // single channel 5
    build_exp(1'b1, 8'd5);
    do_start(1'b1, 8'd5);
    step();
    chk("single_cfg_cycle2", {24'h0, bus.dbg_config_out}, 5);
    wait_done(100, -1);
    cmp_frame("single");
    chk("single_done_cycle", done_cyc, 5);
    chk("single_cfg_hold", {24'h0, bus.dbg_config_out}, 5);

    // random channel values, 50% backpressure, ignored start mid-frame
    for (int k = 0; k < NP; k++) pot[k] = 8'($urandom);
    for (int k = 0; k < 3; k++) spk[k] = 8'($urandom);
    build_exp(1'b0, 8'h00);
    do_start(1'b0, 8'h00);
    wait_done(50, 20);
    cmp_frame("bp");
    chk("bp_latency_ge_83", {31'h0, (done_cyc >= 83)}, 1);

    // random single channel with backpressure
    begin
      int   r;
      logic [7:0] code;
      r    = $urandom_range(NP + 2);
      code = (r < NP) ? 8'(r) : 8'(30 + r - NP);
      build_exp(1'b1, code);
      do_start(1'b1, code);
      wait_done(60, -1);
      cmp_frame("rsingle");
    end

    // abort during the 10th data SEND while stalled
    build_exp(1'b0, 8'h00);
    do_start(1'b0, 8'h00);
    for (int k = 0; k < 200 && hs_cnt < 10; k++) step();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 10 && !bus.out_valid; k++) step();
    chk("abort_stalled_valid", {31'h0, bus.out_valid}, 1);
    chk("abort_stalled_byte", {24'h0, bus.out_data}, {24'h0, exp_bytes[10]});
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", {31'h0, busy}, 0);
    chk("abort_valid", {31'h0, bus.out_valid}, 0);
    repeat (3) step();
    chk("abort_no_done", done_cnt, 0);
    bus.out_ready = 1'b1;
    do_start(1'b0, 8'h00);
    wait_done(100, -1);
    cmp_frame("post_abort");
    chk("post_abort_done_cycle", done_cyc, 83);

    // reset in a SETTLE cycle
    do_start(1'b0, 8'h00);
    for (int k = 0; k < 20 && !bus.dbg_en; k++) step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_busy", {31'h0, busy}, 0);
    chk("mid_rst_valid", {31'h0, bus.out_valid}, 0);
    chk("mid_rst_data", {24'h0, bus.out_data}, 0);
    chk("mid_rst_en", {31'h0, bus.dbg_en}, 0);
    chk("mid_rst_cfg", {24'h0, bus.dbg_config_out}, 0);
    chk("mid_rst_done", {31'h0, done}, 0);
    step();
    build_exp(1'b1, 8'd31);
    do_start(1'b1, 8'd31);
    wait_done(100, -1);
    cmp_frame("post_rst");
    chk("post_rst_done_cycle", done_cyc, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
